// File: rtl/cross_correlator_pkg.sv
// Shared defaults and FSM encoding for the lag-search cross-correlator.
package cross_correlator_pkg;

  localparam int DEF_N_SAMPLES = 8192;
  localparam int DEF_MAX_LAG   = 16;
  localparam int DEF_ACC_W     = 48;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FLUSH,
    SEARCH,
    DONE
  } xcorr_state_e;

endpackage

// File: rtl/xcorr_mac_lane.sv
// One correlation lane: signed 16x16 multiply feeding a wide accumulator
// with a synchronous clear that wins over accumulation.
module xcorr_mac_lane
  import cross_correlator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [15:0]      a_i,
  input  logic signed [15:0]      b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign prod  = $signed({{16{a_i[15]}}, a_i}) * $signed({{16{b_i[15]}}, b_i});
  assign acc_o = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + $signed({{(ACC_W-32){prod[31]}}, prod});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/cross_correlator.sv
// Block cross-correlator: accumulates R(k) for k in [-MAX_LAG, +MAX_LAG] over
// one block of sample pairs, then serially searches for the peak lag.
module cross_correlator
  import cross_correlator_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int MAX_LAG   = DEF_MAX_LAG,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] m0,
  input  logic signed [15:0] m1,
  output logic signed [15:0] index,
  output logic               done
);

  localparam int LANES  = 2 * MAX_LAG + 1;
  localparam int CNT_W  = $clog2(N_SAMPLES + MAX_LAG);
  localparam int SCAN_W = $clog2(LANES + 1);

  xcorr_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SCAN_W-1:0]       scan_q, scan_d;
  logic [SCAN_W-1:0]       bestLane_q, bestLane_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic signed [15:0]      index_q, index_d;
  logic                    done_q, done_d;

  logic signed [15:0]      m0Dly_q [MAX_LAG];
  logic signed [15:0]      m1Hist_q [2*MAX_LAG];
  logic signed [15:0]      s0, s1;
  logic signed [15:0]      tap [LANES];
  logic signed [ACC_W-1:0] acc [LANES];
  logic signed [ACC_W-1:0] laneVal;
  logic                    clrLanes, shiftEn, accEn;

  assign index = index_q;
  assign done  = done_q;

  always_comb begin
    laneVal = '0;
    for (int i = 0; i < LANES; i++) begin
      if (scan_q == SCAN_W'(i)) laneVal = acc[i];
    end
  end

  // The extra SEARCH cycle at scan_q == LANES publishes the winner.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scan_d     = scan_q;
    bestLane_d = bestLane_q;
    best_d     = best_q;
    index_d    = index_q;
    done_d     = done_q;
    clrLanes   = 1'b0;
    shiftEn    = 1'b0;
    accEn      = 1'b0;
    s0         = '0;
    s1         = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = ACCUM;
          cnt_d      = CNT_W'(1);
          scan_d     = '0;
          bestLane_d = '0;
          best_d     = '0;
          done_d     = 1'b0;
          clrLanes   = 1'b1;
          s0         = m0;
          s1         = m1;
        end
      end
      ACCUM: begin
        shiftEn = 1'b1;
        accEn   = 1'b1;
        s0      = m0;
        s1      = m1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        shiftEn = 1'b1;
        accEn   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MAX_LAG - 1)) begin
          state_d = SEARCH;
          cnt_d   = '0;
          scan_d  = '0;
        end
      end
      SEARCH: begin
        scan_d = scan_q + SCAN_W'(1);
        if (scan_q == SCAN_W'(LANES)) begin
          index_d = 16'(bestLane_q) - 16'(MAX_LAG);
          done_d  = 1'b1;
          state_d = DONE;
        end else if (scan_q == '0 || laneVal > best_q) begin
          best_d     = laneVal;
          bestLane_d = scan_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      scan_q     <= '0;
      bestLane_q <= '0;
      best_q     <= '0;
      index_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scan_q     <= scan_d;
      bestLane_q <= bestLane_d;
      best_q     <= best_d;
      index_q    <= index_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LAG; i++) m0Dly_q[i] <= '0;
      for (int i = 0; i < 2*MAX_LAG; i++) m1Hist_q[i] <= '0;
    end else if (clrLanes) begin
      m0Dly_q[0]  <= s0;
      m1Hist_q[0] <= s1;
      for (int i = 1; i < MAX_LAG; i++) m0Dly_q[i] <= '0;
      for (int i = 1; i < 2*MAX_LAG; i++) m1Hist_q[i] <= '0;
    end else if (shiftEn) begin
      m0Dly_q[0]  <= s0;
      m1Hist_q[0] <= s1;
      for (int i = 1; i < MAX_LAG; i++) m0Dly_q[i] <= m0Dly_q[i-1];
      for (int i = 1; i < 2*MAX_LAG; i++) m1Hist_q[i] <= m1Hist_q[i-1];
    end
  end

  // tap[j] is m1 delayed j cycles; lane i (lag i-MAX_LAG) reads tap[2*MAX_LAG-i].
  assign tap[0] = s1;
  for (genvar j = 1; j < LANES; j++) begin : g_tap
    assign tap[j] = m1Hist_q[j-1];
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    xcorr_mac_lane #(
      .ACC_W(ACC_W)
    ) u_lane (
      .clk_i (clk),
      .rst_ni(rst),
      .clr_i (clrLanes),
      .en_i  (accEn),
      .a_i   (m0Dly_q[MAX_LAG-1]),
      .b_i   (tap[2*MAX_LAG-i]),
      .acc_o (acc[i])
    );
  end

endmodule

// File: tb/tb_cross_correlator.sv
// Scoreboard bench for cross_correlator: expected peak lags are queued as each
// block is driven and checked against index when done rises.
module tb_cross_correlator;

  localparam int N       = 8192;
  localparam int L       = 16;
  localparam int LATENCY = N + 3 * L + 1;

  logic               clk   = 1'b0;
  logic               rst   = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] m0    = '0;
  logic signed [15:0] m1    = '0;
  logic signed [15:0] index;
  logic               done;

  int      testsRun    = 0;
  int      testsFailed = 0;
  int      cycle       = 0;
  int      sb[$];
  shortint m0Arr[N];
  shortint m1Arr[N];

  cross_correlator #(
    .N_SAMPLES(N),
    .MAX_LAG  (L),
    .ACC_W    (48)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .m0   (m0),
    .m1   (m1),
    .index(index),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic fillNoise();
    for (int n = 0; n < N; n++) m0Arr[n] = shortint'($urandom);
  endtask

  task automatic fillDelayed(input int d);
    for (int n = 0; n < N; n++) begin
      if (n - d >= 0 && n - d < N) m1Arr[n] = m0Arr[n-d];
      else m1Arr[n] = 16'sd0;
    end
  endtask

  task automatic driveBlock(input int count, input int startAgainAt,
                            output int startEdge, output logic doneAfterStart);
    @(negedge clk);
    start = 1'b1;
    m0    = m0Arr[0];
    m1    = m1Arr[0];
    @(posedge clk);
    #1;
    startEdge      = cycle;
    doneAfterStart = done;
    for (int n = 1; n < count; n++) begin
      @(negedge clk);
      start = (n == startAgainAt);
      m0    = m0Arr[n];
      m1    = m1Arr[n];
    end
    @(negedge clk);
    start = 1'b0;
    m0    = 16'($urandom);
    m1    = 16'($urandom);
  endtask

  task automatic waitDone(input int startEdge, output int lat);
    lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) lat = cycle - startEdge;
    end
  endtask

  function automatic int popExpected();
    if (sb.size() == 0) return 9999;
    return sb.pop_front();
  endfunction

  function automatic int modelPeak();
    longint best, r;
    int     bestK;
    best  = 0;
    bestK = -L;
    for (int k = -L; k <= L; k++) begin
      r = 0;
      for (int n = 0; n < N; n++) begin
        if (n + k >= 0 && n + k < N) r += longint'(m0Arr[n]) * longint'(m1Arr[n+k]);
      end
      if (k == -L || r > best) begin
        best  = r;
        bestK = k;
      end
    end
    return bestK;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_done: got %b, expected 0", done);
    end
    testsRun++;
    if (index !== 16'sd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_index: got %0d, expected 0", index);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sine_identical();
    int se, lat, exp;
    logic das;
    for (int n = 0; n < N; n++) begin
      m0Arr[n] = shortint'($rtoi(10000.0 * $sin(2.0 * 3.14159265358979 * n / 48.0)));
      m1Arr[n] = m0Arr[n];
    end
    sb.push_back(0);
    driveBlock(N, -1, se, das);
    waitDone(se, lat);
    testsRun++;
    if (lat !== LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL sine_latency: got %0d edges, expected %0d", lat, LATENCY);
    end
    exp = popExpected();
    testsRun++;
    if (index !== 16'(exp)) begin
      testsFailed++;
      $display("[TB] FAIL sine_index: got %0d, expected %0d", index, exp);
    end
  endtask

  task automatic test_delay_pos5();
    int se, lat, exp;
    logic das;
    fillNoise();
    fillDelayed(5);
    sb.push_back(5);
    driveBlock(N, -1, se, das);
    waitDone(se, lat);
    testsRun++;
    if (lat !== LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL delay5_latency: got %0d edges, expected %0d", lat, LATENCY);
    end
    exp = popExpected();
    testsRun++;
    if (index !== 16'(exp)) begin
      testsFailed++;
      $display("[TB] FAIL delay5_index: got %0d, expected %0d", index, exp);
    end
  endtask

  // A second start pulse mid-ACCUM must not disturb timing or the result.
  task automatic test_delay_neg3_with_restart();
    int se, lat, exp;
    logic das;
    fillNoise();
    fillDelayed(-3);
    sb.push_back(-3);
    driveBlock(N, 2000, se, das);
    waitDone(se, lat);
    testsRun++;
    if (lat !== LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL restart_latency: got %0d edges, expected %0d", lat, LATENCY);
    end
    exp = popExpected();
    testsRun++;
    if (index !== 16'(exp)) begin
      testsFailed++;
      $display("[TB] FAIL delay_neg3_index: got %0d, expected %0d", index, exp);
    end
  endtask

  task automatic test_all_zero();
    int se, lat, exp;
    logic das;
    for (int n = 0; n < N; n++) begin
      m0Arr[n] = 16'sd0;
      m1Arr[n] = 16'sd0;
    end
    sb.push_back(-L);
    driveBlock(N, -1, se, das);
    waitDone(se, lat);
    testsRun++;
    if (lat !== LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL zero_latency: got %0d edges, expected %0d", lat, LATENCY);
    end
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL zero_done: got %b, expected 1", done);
    end
    exp = popExpected();
    testsRun++;
    if (index !== 16'(exp)) begin
      testsFailed++;
      $display("[TB] FAIL zero_tie_index: got %0d, expected %0d", index, exp);
    end
  endtask

  task automatic test_reset_mid_block();
    int se;
    logic das, sawDone;
    fillNoise();
    fillDelayed(7);
    driveBlock(4000, -1, se, das);
    rst = 1'b0;
    #1;
    testsRun++;
    if (done !== 1'b0 || index !== 16'sd0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got done=%b index=%0d, expected done=0 index=0", done, index);
    end
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (done !== 1'b0 || index !== 16'sd0) begin
      testsFailed++;
      $display("[TB] FAIL held_reset: got done=%b index=%0d, expected done=0 index=0", done, index);
    end
    @(negedge clk);
    rst     = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 4400; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || index !== 16'sd0) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abandoned_block: got result activity=%b, expected 0", sawDone);
    end
  endtask

  task automatic test_delay_pos7_after_reset();
    int se, lat, exp;
    logic das;
    fillNoise();
    fillDelayed(7);
    sb.push_back(7);
    driveBlock(N, -1, se, das);
    waitDone(se, lat);
    testsRun++;
    if (lat !== LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL delay7_latency: got %0d edges, expected %0d", lat, LATENCY);
    end
    exp = popExpected();
    testsRun++;
    if (index !== 16'(exp)) begin
      testsFailed++;
      $display("[TB] FAIL delay7_index: got %0d, expected %0d", index, exp);
    end
  endtask

  task automatic test_full_scale_start_in_done();
    int se, lat, exp;
    logic das;
    repeat (20) @(negedge clk);
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL done_hold: got %b, expected 1", done);
    end
    for (int n = 0; n < N; n++) begin
      m0Arr[n] = -16'sd32768;
      m1Arr[n] = -16'sd32768;
    end
    sb.push_back(0);
    driveBlock(N, -1, se, das);
    testsRun++;
    if (das !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL start_in_done: got done=%b after start edge, expected 0", das);
    end
    waitDone(se, lat);
    testsRun++;
    if (lat !== LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL fullscale_latency: got %0d edges, expected %0d", lat, LATENCY);
    end
    exp = popExpected();
    testsRun++;
    if (index !== 16'(exp)) begin
      testsFailed++;
      $display("[TB] FAIL fullscale_index: got %0d, expected %0d", index, exp);
    end
  endtask

  task automatic test_random_model();
    int se, lat, exp;
    logic das;
    fillNoise();
    for (int n = 0; n < N; n++) m1Arr[n] = shortint'($urandom);
    sb.push_back(modelPeak());
    driveBlock(N, -1, se, das);
    waitDone(se, lat);
    testsRun++;
    if (lat !== LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL random_latency: got %0d edges, expected %0d", lat, LATENCY);
    end
    exp = popExpected();
    testsRun++;
    if (index !== 16'(exp)) begin
      testsFailed++;
      $display("[TB] FAIL random_index: got %0d, expected %0d", index, exp);
    end
    testsRun++;
    if (sb.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drained: got %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_sine_identical();
    test_delay_pos5();
    test_delay_neg3_with_restart();
    test_all_zero();
    test_reset_mid_block();
    test_delay_pos7_after_reset();
    test_full_scale_start_in_done();
    test_random_model();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
